// File: rtl/reg_pipe_pkg.sv
// reg_pipe_pkg
// Shared constants and helpers for the reg_pipe register pipeline.
//   DEFAULT_WIDTH / DEFAULT_DEPTH : default data width and stage count
//   count_width(depth)            : bits needed to hold an occupancy of 0..depth
package reg_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_if.sv
// reg_pipe_if
// Handshake bundle between a producer/consumer pair and the reg_pipe block.
//   CLR                 synchronous flush request
//   IN_VALID/IN_READY   producer side handshake, DIN carries the word
//   OUT_VALID/OUT_READY consumer side handshake, DOUT carries the word
//   COUNT               registered number of occupied stages
//   PAR_ERR             parity mismatch on DOUT (only with REG_PIPE_PARITY_EN)
// Modports: master = the side driving the pipeline (producer + consumer),
//           slave  = the pipeline itself.
interface reg_pipe_if
  import reg_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
);

  localparam int CW = count_width(DEPTH);

  logic             CLR;
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] DIN;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] DOUT;
  logic [CW-1:0]    COUNT;
`ifdef REG_PIPE_PARITY_EN
  logic             PAR_ERR;

  modport master (
    output CLR, IN_VALID, DIN, OUT_READY,
    input  IN_READY, OUT_VALID, DOUT, COUNT, PAR_ERR
  );

  modport slave (
    input  CLR, IN_VALID, DIN, OUT_READY,
    output IN_READY, OUT_VALID, DOUT, COUNT, PAR_ERR
  );
`else
  modport master (
    output CLR, IN_VALID, DIN, OUT_READY,
    input  IN_READY, OUT_VALID, DOUT, COUNT
  );

  modport slave (
    input  CLR, IN_VALID, DIN, OUT_READY,
    output IN_READY, OUT_VALID, DOUT, COUNT
  );
`endif

endinterface

// File: rtl/reg_pipe_stage.sv
// reg_pipe_stage
// One stage of the register pipeline: a valid flop and a data flop with
// load/hold control. Optional parity flop when REG_PIPE_PARITY_EN is defined.
//   CLK, RST  clock and asynchronous active-high reset
//   clr       synchronous flush (clears valid, data holds)
//   load      this stage may take the upstream word this cycle
//   vin, din  upstream valid and data
//   pin/pout  upstream parity / stored parity (REG_PIPE_PARITY_EN only)
//   v, d      stored valid and data
module reg_pipe_stage
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             clr,
  input  logic             load,
  input  logic             vin,
  input  logic [WIDTH-1:0] din,
`ifdef REG_PIPE_PARITY_EN
  input  logic             pin,
  output logic             pout,
`endif
  output logic             v,
  output logic [WIDTH-1:0] d
);

  // Data only moves on a valid incoming word, so a bubble passing through
  // leaves the previous data in place (keeps DOUT quiet on empty cycles).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v <= 1'b0;
      d <= RST_VAL;
    end else if (clr) begin
      v <= 1'b0;
    end else if (load) begin
      v <= vin;
      if (vin) begin
        d <= din;
      end
    end
  end

`ifdef REG_PIPE_PARITY_EN
  // Reset parity matches the reset data so an (invalid) reset word is self-consistent.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pout <= ^RST_VAL;
    end else if (!clr && load && vin) begin
      pout <= pin;
    end
  end
`endif

endmodule

// File: rtl/reg_pipe.sv
// reg_pipe
// WIDTH-bit by DEPTH-stage elastic register pipeline with valid/ready on both
// ends, bubble collapsing, synchronous flush and a registered occupancy count.
// Parameters: WIDTH (data bits), DEPTH (stages), RST_VAL (data reset value).
// Ports:
//   CLK  rising-edge clock
//   RST  asynchronous active-high reset
//   bus  reg_pipe_if.slave: CLR, IN_VALID/IN_READY/DIN,
//        OUT_VALID/OUT_READY/DOUT, COUNT (+ PAR_ERR)
// Optional feature macro: REG_PIPE_PARITY_EN adds per-stage even parity and
// the PAR_ERR output.
// Note: OUT_READY reaches IN_READY combinationally through the ready logic.
module reg_pipe
  import reg_pipe_pkg::*;
#(
  parameter int               WIDTH   = DEFAULT_WIDTH,
  parameter int               DEPTH   = DEFAULT_DEPTH,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic       CLK,
  input  logic       RST,
  reg_pipe_if.slave  bus
);

  localparam int            CW  = count_width(DEPTH);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [DEPTH-1:0] v;
  logic [DEPTH-1:0] rdy;
  logic [WIDTH-1:0] d [DEPTH];
`ifdef REG_PIPE_PARITY_EN
  logic [DEPTH-1:0] p;
`endif
  logic [CW-1:0]    count;
  logic             xfer_in;
  logic             xfer_out;

  genvar i;
  generate
    for (i = 0; i < DEPTH; i++) begin : g_stage
      logic             vin_s;
      logic [WIDTH-1:0] din_s;
`ifdef REG_PIPE_PARITY_EN
      logic             pin_s;
`endif

      // Stage i can move when any stage from i to the output end has a hole,
      // or the consumer takes the last word; this is the unrolled ready chain.
      assign rdy[i] = ~(&v[DEPTH-1:i]) | bus.OUT_READY;

      if (i == 0) begin : g_head
        assign vin_s = bus.IN_VALID;
        assign din_s = bus.DIN;
`ifdef REG_PIPE_PARITY_EN
        assign pin_s = ^bus.DIN;
`endif
      end else begin : g_body
        assign vin_s = v[i-1];
        assign din_s = d[i-1];
`ifdef REG_PIPE_PARITY_EN
        assign pin_s = p[i-1];
`endif
      end

      reg_pipe_stage #(
        .WIDTH   (WIDTH),
        .RST_VAL (RST_VAL)
      ) u_stage (
        .CLK  (CLK),
        .RST  (RST),
        .clr  (bus.CLR),
        .load (rdy[i]),
        .vin  (vin_s),
        .din  (din_s),
`ifdef REG_PIPE_PARITY_EN
        .pin  (pin_s),
        .pout (p[i]),
`endif
        .v    (v[i]),
        .d    (d[i])
      );
    end
  endgenerate

  assign bus.IN_READY  = rdy[0] & ~bus.CLR;
  assign bus.OUT_VALID = v[DEPTH-1] & ~bus.CLR;
  assign bus.DOUT      = d[DEPTH-1];
  assign bus.COUNT     = count;

`ifdef REG_PIPE_PARITY_EN
  assign bus.PAR_ERR   = bus.OUT_VALID & (^bus.DOUT ^ p[DEPTH-1]);
`endif

  assign xfer_in  = bus.IN_VALID & bus.IN_READY;
  assign xfer_out = bus.OUT_VALID & bus.OUT_READY;

  // Occupancy tracks transfers, so it always equals the number of valid stages.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count <= '0;
    end else if (bus.CLR) begin
      count <= '0;
    end else if (xfer_in && !xfer_out) begin
      count <= count + ONE;
    end else if (!xfer_in && xfer_out) begin
      count <= count - ONE;
    end
  end

endmodule

// File: tb/tb_reg_pipe.sv
// tb_reg_pipe
// Self-checking bench for reg_pipe (WIDTH=8, DEPTH=4, RST_VAL=8'hA5).
// A negedge scoreboard keeps an ordered queue of accepted words with their
// acceptance cycle. A word reaches the output DEPTH cycles after acceptance,
// or one cycle after its predecessor leaves, whichever is later; IN_READY is
// high unless flushing or the pipe is full with the consumer stalled.
// Parity checks are added when REG_PIPE_PARITY_EN is defined.
module tb_reg_pipe;

  localparam int         WIDTH   = 8;
  localparam int         DEPTH   = 4;
  localparam logic [7:0] RST_VAL = 8'hA5;

  typedef struct {
    logic [WIDTH-1:0] data;
    int               acc;
  } word_t;

  logic  CLK = 1'b0;
  logic  RST;
  int    checks   = 0;
  int    failures = 0;
  int    cycleNo  = 0;
  int    lastOut  = -1000;
  bit    parForce = 1'b0;
  word_t sb[$];

  always #5 CLK = ~CLK;

  reg_pipe_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  reg_pipe #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .RST_VAL (RST_VAL)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, actual, expected, cycleNo);
    end
  endtask

  task automatic applyStimulus(input logic iv, input logic [WIDTH-1:0] din,
                               input logic ordy, input logic clr);
    @(posedge CLK);
    #1;
    bus.IN_VALID  = iv;
    bus.DIN       = din;
    bus.OUT_READY = ordy;
    bus.CLR       = clr;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_dout"},      bus.DOUT,      RST_VAL);
    checkOutput({tag, "_out_valid"}, bus.OUT_VALID, 0);
    checkOutput({tag, "_in_ready"},  bus.IN_READY,  1);
    checkOutput({tag, "_count"},     bus.COUNT,     0);
  endtask

  always @(posedge CLK) cycleNo <= cycleNo + 1;

  // Scoreboard: predicts handshakes and occupancy, pops on every DUT output transfer.
  always @(negedge CLK) begin
    if (RST) begin
      sb.delete();
    end else begin
      logic  expRdy;
      logic  expOv;
      int    due;
      word_t w;
      expRdy = !bus.CLR && (sb.size() < DEPTH || bus.OUT_READY);
      expOv  = 1'b0;
      if (!bus.CLR && sb.size() > 0) begin
        due = sb[0].acc + DEPTH;
        if (lastOut + 1 > due) due = lastOut + 1;
        expOv = (cycleNo >= due);
      end
      checkOutput("in_ready",  bus.IN_READY,  expRdy);
      checkOutput("out_valid", bus.OUT_VALID, expOv);
      checkOutput("count",     bus.COUNT,     sb.size());
`ifdef REG_PIPE_PARITY_EN
      if (!parForce) checkOutput("par_err", bus.PAR_ERR, 0);
`endif
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (sb.size() == 0) begin
          checkOutput("pop_empty", 1, 0);
        end else begin
          w = sb.pop_front();
          checkOutput("dout", bus.DOUT, w.data);
          lastOut = cycleNo;
        end
      end
      if (bus.IN_VALID && expRdy) sb.push_back('{data: bus.DIN, acc: cycleNo});
      if (bus.CLR) sb.delete();
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    RST           = 1'b1;
    bus.CLR       = 1'b0;
    bus.IN_VALID  = 1'b0;
    bus.DIN       = '0;
    bus.OUT_READY = 1'b0;

    // Reset state
    @(posedge CLK);
    #3;
    checkResetState("reset");
    RST = 1'b0;
    #1;
    checkResetState("after_reset");

    // Streaming: word k out four cycles after it was offered
    for (int k = 1; k <= 12; k++) begin
      applyStimulus(1'b1, WIDTH'(k), 1'b1, 1'b0);
      #1;
      if (k >= 5) begin
        checkOutput("stream_valid", bus.OUT_VALID, 1);
        checkOutput("stream_dout",  bus.DOUT,      k - 4);
        checkOutput("stream_count", bus.COUNT,     DEPTH);
      end
    end
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Back-pressure: four words fill the pipe, fifth waits
    for (int k = 1; k <= 7; k++) begin
      applyStimulus(1'b1, (k > 5) ? 8'h15 : WIDTH'(8'h10 + k), 1'b0, 1'b0);
    end
    #1;
    checkOutput("bp_in_ready", bus.IN_READY,  0);
    checkOutput("bp_count",    bus.COUNT,     DEPTH);
    checkOutput("bp_dout",     bus.DOUT,      8'h11);
    checkOutput("bp_valid",    bus.OUT_VALID, 1);
    applyStimulus(1'b1, 8'h15, 1'b1, 1'b0);
    #1;
    checkOutput("bp_full_pass", bus.IN_READY, 1);
    applyStimulus(1'b1, 8'h16, 1'b1, 1'b0);
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Bubble collapse: gap between two words closes while the output stalls
    applyStimulus(1'b1, 8'h21, 1'b0, 1'b0);
    repeat (3) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
    repeat (2) applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    checkOutput("bubble_count", bus.COUNT, 2);
    checkOutput("bubble_dout",  bus.DOUT,  8'h21);
    repeat (6) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    // Flush with a word offered in the same cycle
    applyStimulus(1'b1, 8'h31, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h32, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h34, 1'b1, 1'b1);
    #1;
    checkOutput("clr_count_before", bus.COUNT,     3);
    checkOutput("clr_in_ready",     bus.IN_READY,  0);
    checkOutput("clr_out_valid",    bus.OUT_VALID, 0);
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    #1;
    checkOutput("clr_count_after", bus.COUNT,     0);
    checkOutput("clr_valid_after", bus.OUT_VALID, 0);

`ifdef REG_PIPE_PARITY_EN
    // Parity: corrupt DOUT while a valid word waits at the output
    for (int k = 1; k <= 4; k++) applyStimulus(1'b1, WIDTH'(8'h40 + k), 1'b0, 1'b0);
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    #1;
    parForce = 1'b1;
    force bus.DOUT = 8'h40;
    #1;
    checkOutput("par_err_forced", bus.PAR_ERR, 1);
    release bus.DOUT;
    #1;
    checkOutput("par_err_released", bus.PAR_ERR, 0);
    parForce = 1'b0;
    repeat (8) applyStimulus(1'b0, '0, 1'b1, 1'b0);
`endif

    // Randomised traffic with varying consumer pressure, rare flushes and one mid-stream reset
    for (int n = 0; n < 3000; n++) begin
      int readyPct;
      readyPct = ((n / 200) % 3 == 0) ? 90 : (((n / 200) % 3 == 1) ? 30 : 60);
      applyStimulus(($urandom % 4) != 0, WIDTH'($urandom),
                    ($urandom % 100) < readyPct, ($urandom % 40) == 0);
      if (n == 1500) begin
        @(posedge CLK);
        #1;
        bus.CLR = 1'b0;
        #2;
        RST = 1'b1;
        #1;
        checkResetState("midreset");
        @(posedge CLK);
        #3;
        RST = 1'b0;
      end
    end
    repeat (10) applyStimulus(1'b0, '0, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
